mem_port_arbiter: RTL and testbench

Shares one single-port memory between the instruction-fetch requester (I) and the memory-access requester (D) of the RV32 pipeline. At most one transaction is outstanding at a time. D has priority over I, and a bounded-streak counter keeps I from starving. Sits between the fetch/memory-access stages and the unified RAM. Its per-port grant and response strobes drive the pipeline hold logic.

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between the instruction-fetch (I)
// and memory-access (D) requesters. One transaction in flight at a time. D has
// priority; a streak counter forces an I grant after STARVE_LIMIT consecutive
// D grants that each found I waiting.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        asrst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wren,
  input  logic [31:0] d_wrdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wren,
  output logic [31:0] mem_wrdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;      // 0 = I, 1 = D
  logic [3:0]  streak_q, streak_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wren_q, mem_wren_d;
  logic [31:0] mem_wrdata_q, mem_wrdata_d;
  logic        d_win;

  // D wins unless I is waiting and has already been passed over LIMIT times
  assign d_win = d_req && !(i_req && (streak_q == LIMIT));

  assign i_rdata    = mem_rdata;
  assign d_rdata    = mem_rdata;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wren   = mem_wren_q;
  assign mem_wrdata = mem_wrdata_q;
  assign busy       = (state_q != IDLE);

  // Next-state, grant and response decode
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    streak_d     = streak_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wren_d   = mem_wren_q;
    mem_wrdata_d = mem_wrdata_q;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    i_rvalid     = 1'b0;
    d_rvalid     = 1'b0;
    case (state_q)
      IDLE: begin
        // stale mem_rvalid here is dropped on the floor
        if (d_win) begin
          d_gnt        = 1'b1;
          owner_d      = 1'b1;
          mem_addr_d   = d_addr;
          mem_wren_d   = d_wren;
          mem_wrdata_d = d_wrdata;
          mem_req_d    = 1'b1;
          state_d      = REQ;
          if (!i_req)              streak_d = 4'd0;
          else if (streak_q < LIMIT) streak_d = streak_q + 4'd1;
        end else if (i_req) begin
          i_gnt        = 1'b1;
          owner_d      = 1'b0;
          mem_addr_d   = i_addr;
          mem_wren_d   = 4'd0;
          mem_wrdata_d = 32'd0;
          mem_req_d    = 1'b1;
          state_d      = REQ;
          streak_d     = 4'd0;
        end
      end
      REQ: begin
        // mem_rvalid before the request is accepted cannot belong to it
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = RSP;
        end
      end
      RSP: begin
        if (mem_rvalid) begin
          d_rvalid = owner_q;
          i_rvalid = !owner_q;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and memory-side request registers
  always_ff @(posedge clk or negedge asrst_n) begin
    if (!asrst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      streak_q     <= 4'd0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wren_q   <= 4'd0;
      mem_wrdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      streak_q     <= streak_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wren_q   <= mem_wren_d;
      mem_wrdata_q <= mem_wrdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed stimulus drives the two requesters and a
// hand-played memory; expected responses go into a scoreboard queue that a
// separate monitor drains whenever either rvalid fires.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        asrst_n;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wrdata;
  logic [3:0]  d_wren;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_ready, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wrdata, mem_rdata;
  logic [3:0]  mem_wren;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        port;   // 1 = D
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .asrst_n(asrst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wren(d_wren), .d_wrdata(d_wrdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wrdata(mem_wrdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Response monitor: every rvalid must match the oldest expected response
  always @(negedge clk) begin
    if (asrst_n === 1'b1 && (i_rvalid === 1'b1 || d_rvalid === 1'b1)) begin
      exp_t e;
      checks++;
      if (i_rvalid && d_rvalid) begin
        failures++;
        $display("FAIL rvalid_both actual=11 required=one port");
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rvalid_unexpected actual=i%0b/d%0b required=none", i_rvalid, d_rvalid);
      end else begin
        e = exp_q.pop_front();
        if (d_rvalid !== e.port || (e.port ? d_rdata : i_rdata) !== e.data) begin
          failures++;
          $display("FAIL rsp actual=port%0b/%h required=port%0b/%h",
                   d_rvalid, e.port ? d_rdata : i_rdata, e.port, e.data);
        end
      end
    end
  end

  // One transaction from IDLE; requester inputs are already set by the caller.
  task automatic txn(input string nm, input bit exp_d, input logic [31:0] ea,
                     input logic [3:0] ew, input logic [31:0] ewd, input int stall,
                     input int lat, input logic [31:0] rd, input bit drop, input bit stray);
    exp_t e;
    @(negedge clk);
    chk({nm, " gnt"}, 32'({d_gnt, i_gnt}), exp_d ? 32'd2 : 32'd1);
    chk({nm, " idle_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    if (drop) begin
      if (exp_d) d_req = 1'b0;
      else       i_req = 1'b0;
    end
    mem_ready  = (stall == 0);
    mem_rvalid = stray;
    for (int k = 0; k <= stall; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        mem_ready  = (k == stall);
        mem_rvalid = 1'b0;
      end
      @(negedge clk);
      chk({nm, " mem_req"}, 32'({mem_req, busy, d_gnt, i_gnt}), 32'hC);
      chk({nm, " mem_addr"}, mem_addr, ea);
      chk({nm, " mem_wren"}, 32'(mem_wren), 32'(ew));
      chk({nm, " mem_wrdata"}, mem_wrdata, ewd);
    end
    for (int k = 0; k <= lat; k++) begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (k == lat) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        e.port = exp_d;
        e.data = rd;
        exp_q.push_back(e);
      end
      @(negedge clk);
      chk({nm, " rsp_state"}, 32'({mem_req, busy, d_gnt, i_gnt}), 32'h4);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    asrst_n = 1'b0; i_req = 0; d_req = 0; i_addr = 0; d_addr = 0; d_wren = 0;
    d_wrdata = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;

    // reset state
    @(negedge clk);
    chk("rst outputs", 32'({busy, mem_req, i_gnt, d_gnt, i_rvalid, d_rvalid}), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wrdata", mem_wrdata, 32'd0);
    chk("rst mem_wren", 32'(mem_wren), 32'd0);
    @(posedge clk); #1; asrst_n = 1'b1;
    @(posedge clk); #1;

    // single I read
    i_req = 1; i_addr = 32'h100;
    txn("i_read", 0, 32'h100, 4'h0, 32'h0, 0, 0, 32'hDEADBEEF, 1, 0);
    @(negedge clk); chk("i_read busy_n3", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // D write with 3 cycles of backpressure
    d_req = 1; d_addr = 32'h200; d_wren = 4'b0011; d_wrdata = 32'h12345678;
    txn("d_write", 1, 32'h200, 4'b0011, 32'h12345678, 3, 1, 32'h0000A5A5, 1, 0);

    // both held: D,D,D,D,I,D
    i_req = 1; i_addr = 32'h300; d_req = 1; d_addr = 32'h400; d_wren = 0; d_wrdata = 0;
    txn("both1_d", 1, 32'h400, 4'h0, 32'h0, 0, 0, 32'h00000001, 0, 0);
    txn("both2_d", 1, 32'h400, 4'h0, 32'h0, 0, 0, 32'h00000002, 0, 0);
    txn("both3_d", 1, 32'h400, 4'h0, 32'h0, 0, 0, 32'h00000003, 0, 0);
    txn("both4_d", 1, 32'h400, 4'h0, 32'h0, 0, 0, 32'h00000004, 0, 0);
    txn("both5_i", 0, 32'h300, 4'h0, 32'h0, 0, 0, 32'h00000005, 0, 0);
    chk("streak after forced I", 32'(dut.streak_q), 32'd0);
    txn("both6_d", 1, 32'h400, 4'h0, 32'h0, 0, 0, 32'h00000006, 0, 0);
    i_req = 0; d_req = 0;

    // lone D read clears the streak; stray mem_rvalid while in REQ
    d_req = 1; d_addr = 32'h500;
    txn("d_read_stray", 1, 32'h500, 4'h0, 32'h0, 1, 2, 32'hCAFEF00D, 1, 1);
    chk("streak after lone D", 32'(dut.streak_q), 32'd0);

    // D contention ends after 2 grants while I waits
    i_req = 1; i_addr = 32'h310; d_req = 1; d_addr = 32'h410;
    txn("cont1_d", 1, 32'h410, 4'h0, 32'h0, 0, 0, 32'h00000011, 0, 0);
    txn("cont2_d", 1, 32'h410, 4'h0, 32'h0, 0, 0, 32'h00000012, 1, 0);
    txn("cont3_i", 0, 32'h310, 4'h0, 32'h0, 0, 0, 32'h00000013, 1, 0);
    chk("streak after contention", 32'(dut.streak_q), 32'd0);

    // stray mem_rvalid in IDLE
    mem_rvalid = 1; mem_rdata = 32'hBADBAD00;
    @(negedge clk); chk("idle stray busy", 32'({busy, mem_req}), 32'd0);
    @(posedge clk); #1; mem_rvalid = 0;
    @(negedge clk); chk("idle stray after", 32'({busy, mem_req}), 32'd0);
    @(posedge clk); #1;

    // reset during RSP, stale completion afterwards
    i_req = 1; i_addr = 32'h600;
    @(negedge clk); chk("rst_rsp gnt", 32'({d_gnt, i_gnt}), 32'd1);
    @(posedge clk); #1; i_req = 0; mem_ready = 1;
    @(negedge clk); chk("rst_rsp mem_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1; mem_ready = 0;
    #2; asrst_n = 1'b0;
    #1; chk("rst_rsp abort", 32'({busy, mem_req, i_rvalid, d_rvalid}), 32'd0);
    chk("rst_rsp mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1; asrst_n = 1'b1; mem_rvalid = 1; mem_rdata = 32'hBAD00BAD;
    @(negedge clk); chk("rst_rsp stale", 32'({busy, mem_req, i_rvalid, d_rvalid}), 32'd0);
    @(posedge clk); #1; mem_rvalid = 0;

    // next request is served normally
    i_req = 1; i_addr = 32'h700;
    txn("post_rst_i", 0, 32'h700, 4'h0, 32'h0, 0, 1, 32'h11112222, 1, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
